// File: rtl/kmeans_assign_seq.sv
// Sequential k-means assignment pass: fetches each point, drives it to an external
// distance unit, resolves the returned code to a cluster label and tallies membership.
module kmeans_assign_seq #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_points,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_x,
    input  logic [31:0]       mem_y,
    output logic [31:0]       x_data,
    output logic [31:0]       y_data,
    output logic              xd_stb,
    output logic              yd_stb,
    output logic              xm_stb,
    output logic              ym_stb,
    input  logic              dist_end,
    input  logic [31:0]       k_in,
    output logic              lbl_we,
    output logic [ADDR_W-1:0] lbl_addr,
    output logic [1:0]        lbl_data,
    output logic [ADDR_W:0]   cnt0,
    output logic [ADDR_W:0]   cnt1,
    output logic [ADDR_W:0]   cnt2,
    output logic              busy,
    output logic              done,
    output logic              tie_flag,
    output logic              timeout_err
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   np_q, np_d;
    logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         x_q, x_d;
    logic [31:0]         y_q, y_d;
    logic                stb_q, stb_d;
    logic                lbl_we_q, lbl_we_d;
    logic [ADDR_W-1:0]   lbl_addr_q, lbl_addr_d;
    logic [1:0]          lbl_data_q, lbl_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tie_q, tie_d;
    logic                tmo_q, tmo_d;
    logic                clr_cnt;
    logic                inc_cnt;
    logic [ADDR_W:0]     idx_inc;
    logic                more_points;
    logic [ADDR_W:0]     cnt_w [3];

    // Codes 3..7 are ties reported by the distance unit; each resolves to a fixed label.
    function automatic logic [1:0] map_code(input logic [31:0] k);
        logic [1:0] lbl;
        case (k)
            32'd1:   lbl = 2'd1;
            32'd2:   lbl = 2'd2;
            32'd4:   lbl = 2'd1;
            default: lbl = 2'd0;
        endcase
        return lbl;
    endfunction

    assign idx_inc     = {1'b0, idx_q} + 1'b1;
    assign more_points = idx_inc < {1'b0, np_q};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        np_d        = np_q;
        wait_cnt_d  = wait_cnt_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        x_d         = x_q;
        y_d         = y_q;
        stb_d       = stb_q;
        lbl_we_d    = 1'b0;
        lbl_addr_d  = lbl_addr_q;
        lbl_data_d  = lbl_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tie_d       = tie_q;
        tmo_d       = tmo_q;
        clr_cnt     = 1'b0;
        inc_cnt     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    np_d       = num_points;
                    idx_d      = '0;
                    wait_cnt_d = '0;
                    busy_d     = 1'b1;
                    tie_d      = 1'b0;
                    tmo_d      = 1'b0;
                    clr_cnt    = 1'b1;
                    if (num_points != '0) begin
                        state_d     = S_FETCH;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                x_d     = mem_x;
                y_d     = mem_y;
                stb_d   = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A result in the last watchdog cycle still counts as a result.
                if (dist_end) begin
                    stb_d      = 1'b0;
                    lbl_we_d   = 1'b1;
                    lbl_addr_d = idx_q;
                    lbl_data_d = map_code(k_in);
                    if (k_in >= 32'd3) begin
                        tie_d = 1'b1;
                    end
                    state_d = S_WRITE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    stb_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                inc_cnt = 1'b1;
                if (more_points) begin
                    idx_d       = idx_inc[ADDR_W-1:0];
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = idx_inc[ADDR_W-1:0];
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            np_q        <= '0;
            wait_cnt_q  <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            x_q         <= '0;
            y_q         <= '0;
            stb_q       <= 1'b0;
            lbl_we_q    <= 1'b0;
            lbl_addr_q  <= '0;
            lbl_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tie_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            np_q        <= np_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            stb_q       <= stb_d;
            lbl_we_q    <= lbl_we_d;
            lbl_addr_q  <= lbl_addr_d;
            lbl_data_q  <= lbl_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tie_q       <= tie_d;
            tmo_q       <= tmo_d;
        end
    end

    // One saturating membership counter per cluster, bumped on the write cycle.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_cnt
            logic [ADDR_W:0] cnt_q;

            always_ff @(posedge clk) begin
                if (rst || clr_cnt) begin
                    cnt_q <= '0;
                end else if (inc_cnt && (lbl_data_q == 2'(gi)) && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign cnt_w[gi] = cnt_q;
        end
    endgenerate

    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign x_data      = x_q;
    assign y_data      = y_q;
    assign xd_stb      = stb_q;
    assign yd_stb      = stb_q;
    assign xm_stb      = stb_q;
    assign ym_stb      = stb_q;
    assign lbl_we      = lbl_we_q;
    assign lbl_addr    = lbl_addr_q;
    assign lbl_data    = lbl_data_q;
    assign cnt0        = cnt_w[0];
    assign cnt1        = cnt_w[1];
    assign cnt2        = cnt_w[2];
    assign busy        = busy_q;
    assign done        = done_q;
    assign tie_flag    = tie_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_kmeans_assign_seq.sv
// Scoreboard bench for kmeans_assign_seq: directed passes push expected label writes,
// issued coordinates and end-of-pass results; a negedge monitor pops and compares them.
module tb_kmeans_assign_seq;

    localparam int AW  = 10;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] num_points;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_x, mem_y;
    logic [31:0]   x_data, y_data;
    logic          xd_stb, yd_stb, xm_stb, ym_stb;
    logic          dist_end;
    logic [31:0]   k_in;
    logic          lbl_we;
    logic [AW-1:0] lbl_addr;
    logic [1:0]    lbl_data;
    logic [AW:0]   cnt0, cnt1, cnt2;
    logic          busy, done, tie_flag, timeout_err;

    always #5 clk = ~clk;

    kmeans_assign_seq #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_points(num_points),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y),
        .x_data(x_data), .y_data(y_data),
        .xd_stb(xd_stb), .yd_stb(yd_stb), .xm_stb(xm_stb), .ym_stb(ym_stb),
        .dist_end(dist_end), .k_in(k_in),
        .lbl_we(lbl_we), .lbl_addr(lbl_addr), .lbl_data(lbl_data),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2),
        .busy(busy), .done(done), .tie_flag(tie_flag), .timeout_err(timeout_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [AW+1:0]   exp_lbl[$];
    logic [63:0]     exp_xy[$];
    logic [3*AW+4:0] exp_done[$];
    int              code_q[$];
    int              resp_lat = 10;
    int              done_cnt = 0;
    int              rd_cnt = 0;
    int              scnt = 0;
    logic            rd_prev = 1'b0;
    logic [AW-1:0]   a_prev = '0;
    logic            stb_prev = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] px(input int a);
        return 32'h4000_0000 + 32'(a) * 32'h0001_0101;
    endfunction

    function automatic logic [31:0] py(input int a);
        return 32'hC100_0000 + 32'(a) * 32'h0000_1111;
    endfunction

    // Point memory: data valid only in the cycle after the read strobe.
    initial begin
        mem_x = '0;
        mem_y = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_prev) begin
                mem_x = px(int'(a_prev));
                mem_y = py(int'(a_prev));
            end else begin
                mem_x = 32'hDEAD_BEEF;
                mem_y = 32'hBAD0_BAD0;
            end
            rd_prev = mem_rd_en;
            a_prev  = mem_addr;
        end
    end

    // Distance unit: answers resp_lat strobe-high cycles after the strobes rise.
    initial begin
        dist_end = 1'b0;
        k_in     = 32'd7;
        forever begin
            @(posedge clk);
            #1;
            if (xd_stb && code_q.size() != 0) begin
                scnt++;
                if (scnt == resp_lat) begin
                    dist_end = 1'b1;
                    k_in     = 32'(code_q.pop_front());
                end else begin
                    dist_end = 1'b0;
                    k_in     = 32'd7;
                end
            end else begin
                scnt     = 0;
                dist_end = 1'b0;
                k_in     = 32'd7;
            end
        end
    end

    // Monitor
    initial begin
        logic [AW+1:0]   el;
        logic [63:0]     exy;
        logic [3*AW+4:0] ed;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_rd_en) rd_cnt++;
                if (lbl_we) begin
                    if (exp_lbl.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_lbl_we: got addr %0d data %0d, expected no write", lbl_addr, lbl_data);
                    end else begin
                        el = exp_lbl.pop_front();
                        check("lbl_write", 64'({lbl_addr, lbl_data}), 64'(el));
                    end
                end
                if (xd_stb && !stb_prev) begin
                    if (exp_xy.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_issue: got x %0h y %0h, expected no issue", x_data, y_data);
                    end else begin
                        exy = exp_xy.pop_front();
                        check("issue_xy", {x_data, y_data}, exy);
                        check("issue_strobes", 64'({xd_stb, yd_stb, xm_stb, ym_stb}), 64'hF);
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (exp_done.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected none");
                    end else begin
                        ed = exp_done.pop_front();
                        check("done_result", 64'({cnt0, cnt1, cnt2, tie_flag, timeout_err}), 64'(ed));
                        check("busy_at_done", 64'(busy), 64'd0);
                    end
                end
            end
            stb_prev = xd_stb;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_issue(input int a);
        exp_xy.push_back({px(a), py(a)});
    endtask

    task automatic push_point(input int a, input int code, input int label);
        code_q.push_back(code);
        exp_lbl.push_back({a[AW-1:0], label[1:0]});
    endtask

    task automatic push_done(input int c0, input int c1, input int c2, input bit tie, input bit tmo);
        exp_done.push_back({c0[AW:0], c1[AW:0], c2[AW:0], tie, tmo});
    endtask

    task automatic start_pass(input int np);
        num_points = np[AW-1:0];
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == d0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_done_timeout: got no done in %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic finish_test(input string name, input int reads, input int r0);
        repeat (3) tick();
        check({name, "_reads"}, 64'(rd_cnt - r0), 64'(reads));
        check({name, "_lbl_left"}, 64'(exp_lbl.size()), 64'd0);
        check({name, "_xy_left"}, 64'(exp_xy.size()), 64'd0);
        check({name, "_done_left"}, 64'(exp_done.size()), 64'd0);
        code_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int hi;
        bit seen;
        bit found;

        rst        = 1'b1;
        start      = 1'b0;
        num_points = '0;
        repeat (3) tick();
        check("reset_ctrl", 64'({busy, done, mem_rd_en, lbl_we, xd_stb, yd_stb, xm_stb, ym_stb, tie_flag, timeout_err}), 64'd0);
        check("reset_cnt", 64'({cnt0, cnt1, cnt2}), 64'd0);
        check("reset_data", {x_data, y_data}, 64'd0);
        rst = 1'b0;
        tick();

        // Three points, one per cluster
        r0 = rd_cnt;
        resp_lat = 10;
        push_issue(0); push_issue(1); push_issue(2);
        push_point(0, 0, 0); push_point(1, 2, 2); push_point(2, 1, 1);
        push_done(1, 1, 1, 1'b0, 1'b0);
        start_pass(3);
        check("A_busy_after_start", 64'(busy), 64'd1);
        wait_done("A", 300);
        finish_test("A", 3, r0);

        // Tie codes 3 and 4
        r0 = rd_cnt;
        push_issue(0); push_issue(1);
        push_point(0, 3, 0); push_point(1, 4, 1);
        push_done(1, 1, 0, 1'b1, 1'b0);
        start_pass(2);
        wait_done("B", 300);
        finish_test("B", 2, r0);

        // Tie codes 5..7 with the shortest distance latency
        r0 = rd_cnt;
        resp_lat = 2;
        push_issue(0); push_issue(1); push_issue(2);
        push_point(0, 5, 0); push_point(1, 6, 0); push_point(2, 7, 0);
        push_done(3, 0, 0, 1'b1, 1'b0);
        start_pass(3);
        wait_done("G", 300);
        finish_test("G", 3, r0);

        // Empty pass
        r0 = rd_cnt;
        push_done(0, 0, 0, 1'b0, 1'b0);
        start_pass(0);
        check("C_busy", 64'(busy), 64'd1);
        check("C_done_early", 64'(done), 64'd0);
        tick();
        check("C_done_2cyc", 64'(done), 64'd1);
        finish_test("C", 0, r0);

        // Distance unit never answers
        r0 = rd_cnt;
        push_issue(0);
        push_done(0, 0, 0, 1'b0, 1'b1);
        start_pass(1);
        hi = 0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (xd_stb) begin
                hi++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            tick();
        end
        check("D_stb_cycles", 64'(hi), 64'd17);
        check("D_tmo_at_drop", 64'(timeout_err), 64'd1);
        wait_done("D", 10);
        finish_test("D", 1, r0);

        // Reset in WAIT of point 1
        r0 = rd_cnt;
        resp_lat = 12;
        push_issue(0); push_issue(1);
        push_point(0, 1, 1);
        code_q.push_back(0); code_q.push_back(0); code_q.push_back(0);
        start_pass(4);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (mem_rd_en && mem_addr == 10'd1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("E_fetch_pt1", 64'(found), 64'd1);
        repeat (3) tick();
        check("E_in_wait", 64'(xd_stb), 64'd1);
        rst = 1'b1;
        tick();
        check("E_abort_ctrl", 64'({busy, done, mem_rd_en, lbl_we, xd_stb, yd_stb, xm_stb, ym_stb, tie_flag, timeout_err}), 64'd0);
        check("E_abort_cnt", 64'({cnt0, cnt1, cnt2}), 64'd0);
        check("E_abort_data", {x_data, y_data}, 64'd0);
        check("E_abort_addr", 64'({mem_addr, lbl_addr, lbl_data}), 64'd0);
        rst = 1'b0;
        code_q.delete();
        repeat (20) tick();
        finish_test("E", 2, r0);

        // Clean pass after the abort
        r0 = rd_cnt;
        resp_lat = 10;
        push_issue(0); push_issue(1);
        push_point(0, 2, 2); push_point(1, 0, 0);
        push_done(1, 0, 1, 1'b0, 1'b0);
        start_pass(2);
        wait_done("E2", 300);
        finish_test("E2", 2, r0);

        // Second start while busy is ignored
        r0 = rd_cnt;
        push_issue(0); push_issue(1); push_issue(2);
        push_point(0, 0, 0); push_point(1, 2, 2); push_point(2, 1, 1);
        push_done(1, 1, 1, 1'b0, 1'b0);
        start_pass(3);
        repeat (5) tick();
        num_points = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_points = 10'd3;
        check("F_busy_kept", 64'(busy), 64'd1);
        wait_done("F", 300);
        finish_test("F", 3, r0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
